renderizador_texto: RTL and testbench

RENDERIZADOR_TEXTO -- requirements
Module: renderizador_texto

---
 rtl/renderizador_texto.sv | 182 ++++++++++++++++++
 tb/tb_renderizador_texto.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/renderizador_texto.sv
// renderizador_texto: one row of 8x16 text cells drawn over a raster scan.
// Three register stages: window/cell decode, buffer + glyph ROM lookup, pixel colouring.
// Optional blinking cursor enabled by defining CURSOR_PARPADEO_EN.
module renderizador_texto #(
  parameter int unsigned NUM_CAR          = 8,
  parameter int unsigned X0               = 0,
  parameter int unsigned Y0               = 0,
  parameter int unsigned PERIODO_PARPADEO = 30
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [9:0] X,
  input  logic [9:0] Y,
  input  logic       R,
  input  logic       G,
  input  logic       B,
  input  logic       we,
  input  logic [4:0] waddr,
  input  logic [3:0] wdata,
  input  logic [4:0] cursor_pos,
  output logic [2:0] L
);

  localparam int unsigned XEnd = X0 + 8 * NUM_CAR;
  localparam int unsigned YEnd = Y0 + 16;

  // Glyph ROM: 16 glyphs of 16 rows, top row in the most significant byte.
  function automatic logic [7:0] f_glyph(input logic [3:0] code, input logic [3:0] row);
    logic [127:0] w_bits;
    case (code)
      4'd0:    w_bits = 128'h00007CC6C6CEDEF6E6C6C67C00000000;
      4'd1:    w_bits = 128'h0000183878D81818181818187E000000;
      4'd2:    w_bits = 128'h00007CC6060C183060C0C6FE00000000;
      4'd3:    w_bits = 128'h00007CC606063C060606C67C00000000;
      4'd4:    w_bits = 128'h00000C1C3C6CCCFE0C0C0C1E00000000;
      4'd5:    w_bits = 128'h0000FEC0C0C0FC060606C67C00000000;
      4'd6:    w_bits = 128'h00003860C0C0FCC6C6C6C67C00000000;
      4'd7:    w_bits = 128'h0000FEC606060C183030303000000000;
      4'd8:    w_bits = 128'h00007CC6C6C67CC6C6C6C67C00000000;
      4'd9:    w_bits = 128'h00007CC6C6C67E0606060C7800000000;
      4'd10:   w_bits = 128'h00000000181800000018180000000000; // ':'
      4'd11:   w_bits = 128'h00000002060C183060C0800000000000; // '/'
      4'd12:   w_bits = 128'h000010386CC6C6FEC6C6C6C600000000; // 'A'
      4'd13:   w_bits = 128'h0000FC6666667C60606060F000000000; // 'P'
      4'd14:   w_bits = 128'hC6EEFEFED6C6C6C6C6C6C6C6C6C6C6C6; // 'M', full cell height
      default: w_bits = '0;                                      // 15: blank
    endcase
    return w_bits[{~row, 3'b000} +: 8];
  endfunction

  // Stage 1 decode of the incoming coordinate.
  logic       w_win;
  logic [7:0] w_dx;
  logic [3:0] w_dy;
  logic       w_inv;

  assign w_win = ({1'b0, X} >= 11'(X0)) && ({1'b0, X} < 11'(XEnd)) &&
                 ({1'b0, Y} >= 11'(Y0)) && ({1'b0, Y} < 11'(YEnd));
  assign w_dx  = 8'(X - 10'(X0));
  assign w_dy  = 4'(Y - 10'(Y0));

`ifdef CURSOR_PARPADEO_EN
  localparam int unsigned CntW = (PERIODO_PARPADEO > 1) ? $clog2(PERIODO_PARPADEO) : 1;

  logic [CntW-1:0] r_frame;
  logic            r_phase;

  // Frame counter ticks once per frame at the origin pixel; blink phase flips on wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame <= '0;
      r_phase <= 1'b0;
    end else if (X == 10'd0 && Y == 10'd0) begin
      if (r_frame == CntW'(PERIODO_PARPADEO - 1)) begin
        r_frame <= '0;
        r_phase <= ~r_phase;
      end else begin
        r_frame <= r_frame + CntW'(1);
      end
    end
  end

  assign w_inv = r_phase && w_win && ({27'd0, cursor_pos} < NUM_CAR) &&
                 (cursor_pos == w_dx[7:3]);
`else
  logic w_unused_cursor;
  assign w_unused_cursor = ^cursor_pos;
  assign w_inv           = 1'b0;
`endif

  // Character buffer plus a one-entry record of the last write, so a pixel sampled in the
  // same cycle as a write to its cell still sees the code that was there before.
  logic [3:0] r_buf [32];
  logic       r_wr_hit;
  logic [4:0] r_wr_addr;
  logic [3:0] r_wr_old;
  logic       w_we_ok;

  assign w_we_ok = we && ({27'd0, waddr} < NUM_CAR);

  // Buffer write port; out-of-range addresses are dropped.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < 32; i++) r_buf[i] <= 4'hF;
      r_wr_hit  <= 1'b0;
      r_wr_addr <= '0;
      r_wr_old  <= 4'hF;
    end else begin
      r_wr_hit  <= w_we_ok;
      r_wr_addr <= waddr;
      r_wr_old  <= r_buf[waddr];
      if (w_we_ok) r_buf[waddr] <= wdata;
    end
  end

  logic       r_win1;
  logic [4:0] r_cell1;
  logic [2:0] r_px1;
  logic [3:0] r_py1;
  logic [2:0] r_rgb1;
  logic       r_inv1;

  // Stage 1: register window flag, cell/pixel position, colour and cursor hit.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win1  <= 1'b0;
      r_cell1 <= '0;
      r_px1   <= '0;
      r_py1   <= '0;
      r_rgb1  <= '0;
      r_inv1  <= 1'b0;
    end else begin
      r_win1  <= w_win;
      r_cell1 <= w_dx[7:3];
      r_px1   <= w_dx[2:0];
      r_py1   <= w_dy;
      r_rgb1  <= {R, G, B};
      r_inv1  <= w_inv;
    end
  end

  logic [3:0] w_code;
  logic [7:0] w_row;

  assign w_code = (r_wr_hit && r_wr_addr == r_cell1) ? r_wr_old : r_buf[r_cell1];
  assign w_row  = f_glyph(w_code, r_py1);

  logic       r_win2;
  logic [7:0] r_row2;
  logic [2:0] r_px2;
  logic [2:0] r_rgb2;
  logic       r_inv2;

  // Stage 2: register the glyph row for the addressed cell.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_win2 <= 1'b0;
      r_row2 <= '0;
      r_px2  <= '0;
      r_rgb2 <= '0;
      r_inv2 <= 1'b0;
    end else begin
      r_win2 <= r_win1;
      r_row2 <= w_row;
      r_px2  <= r_px1;
      r_rgb2 <= r_rgb1;
      r_inv2 <= r_inv1;
    end
  end

  logic w_bit;

  // Bit 7 is the leftmost pixel, so column px selects bit ~px.
  assign w_bit = r_row2[~r_px2] ^ r_inv2;

  // Stage 3: colour the pixel.
  always_ff @(posedge clk) begin
    if (reset) L <= 3'b000;
    else       L <= (r_win2 && w_bit) ? r_rgb2 : 3'b000;
  end

endmodule

// File: tb/tb_renderizador_texto.sv
// Directed bench for renderizador_texto (X0=16, Y0=32, 8 cells, blink half-period 2 frames).
module tb_renderizador_texto;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] X;
  logic [9:0] Y;
  logic       R;
  logic       G;
  logic       B;
  logic       we;
  logic [4:0] waddr;
  logic [3:0] wdata;
  logic [4:0] cursor_pos;
  logic [2:0] L;

  int n_checks = 0;
  int n_pass   = 0;
  logic [2:0] got [32];

  always #5 clk = ~clk;

  renderizador_texto #(
    .NUM_CAR         (8),
    .X0              (16),
    .Y0              (32),
    .PERIODO_PARPADEO(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .X         (X),
    .Y         (Y),
    .R         (R),
    .G         (G),
    .B         (B),
    .we        (we),
    .waddr     (waddr),
    .wdata     (wdata),
    .cursor_pos(cursor_pos),
    .L         (L)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reset with the pointer parked at the frame origin, then move it off the origin.
  task automatic do_reset();
    reset = 1'b1; we = 1'b0; X = 10'd0; Y = 10'd0;
    step();
    step();
    reset = 1'b0; X = 10'd0; Y = 10'd1;
  endtask

  task automatic wr(input logic [4:0] a, input logic [3:0] d);
    we = 1'b1; waddr = a; wdata = d;
    step();
    we = 1'b0;
  endtask

  // Drive n consecutive pixels on row y from column xs; got[j] receives the L for pixel j.
  task automatic run_scan(input int xs, input int y, input logic [2:0] rgb, input int n,
                          input int wr_at, input logic [4:0] wa, input logic [3:0] wd);
    {R, G, B} = rgb;
    for (int i = 0; i < n + 2; i++) begin
      if (i < n) begin X = 10'(xs + i); Y = 10'(y); end
      else begin X = 10'd0; Y = 10'd1; end
      we = (i == wr_at); waddr = wa; wdata = wd;
      step();
      if (i >= 2) got[i-2] = L;
    end
    we = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; X = 10'd0; Y = 10'd0; {R, G, B} = 3'b111;
    we = 1'b0; waddr = '0; wdata = '0; cursor_pos = 5'd31;
    step();
    step();
    n_checks++;
    if (L !== 3'b000) $display("FAIL reset_hold: L=%b expected 000", L);
    else n_pass++;
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      n_checks++;
      if (L !== 3'b000) $display("FAIL after_reset edge%0d: L=%b expected 000", i, L);
      else n_pass++;
    end
    run_scan(16, 35, 3'b111, 16, -1, 5'd0, 4'd0);
    for (int j = 0; j < 16; j++) begin
      n_checks++;
      if (got[j] !== 3'b000) $display("FAIL blank_buffer px%0d: L=%b expected 000", j, got[j]);
      else n_pass++;
    end
  endtask

  task automatic test_glyph();
    logic [0:15] lit;
    logic [2:0]  want;
    do_reset();
    // '1' in cell 0, row 5 = D8, columns 15..24
    wr(5'd0, 4'd1);
    run_scan(15, 37, 3'b100, 10, -1, 5'd0, 4'd0);
    lit = 16'h6C00;
    for (int j = 0; j < 10; j++) begin
      want = lit[j] ? 3'b100 : 3'b000;
      n_checks++;
      if (got[j] !== want) $display("FAIL glyph_one_row5 px%0d: L=%b expected %b", j, got[j], want);
      else n_pass++;
    end
    // 'A' in cell 2, row 7 = FE, columns 31..40
    wr(5'd2, 4'd12);
    run_scan(31, 39, 3'b011, 10, -1, 5'd0, 4'd0);
    lit = 16'h7F00;
    for (int j = 0; j < 10; j++) begin
      want = lit[j] ? 3'b011 : 3'b000;
      n_checks++;
      if (got[j] !== want) $display("FAIL glyph_A_row7 px%0d: L=%b expected %b", j, got[j], want);
      else n_pass++;
    end
    // '4' in last cell 7, row 6 = CC, columns 71..80 (80 is past the window)
    wr(5'd7, 4'd4);
    run_scan(71, 38, 3'b110, 10, -1, 5'd0, 4'd0);
    lit = 16'h6600;
    for (int j = 0; j < 10; j++) begin
      want = lit[j] ? 3'b110 : 3'b000;
      n_checks++;
      if (got[j] !== want) $display("FAIL glyph_4_row6 px%0d: L=%b expected %b", j, got[j], want);
      else n_pass++;
    end
  endtask

  task automatic test_write_collision();
    logic [0:15] lit;
    logic [2:0]  want;
    do_reset();
    // Write '1' into cell 3 in the same cycle pixel 1 of that cell is presented.
    run_scan(40, 37, 3'b111, 8, 1, 5'd3, 4'd1);
    lit = 16'h1800;
    for (int j = 0; j < 8; j++) begin
      want = lit[j] ? 3'b111 : 3'b000;
      n_checks++;
      if (got[j] !== want) $display("FAIL collision px%0d: L=%b expected %b", j, got[j], want);
      else n_pass++;
    end
    run_scan(40, 37, 3'b111, 8, -1, 5'd0, 4'd0);
    lit = 16'hD800;
    for (int j = 0; j < 8; j++) begin
      want = lit[j] ? 3'b111 : 3'b000;
      n_checks++;
      if (got[j] !== want) $display("FAIL after_collision px%0d: L=%b expected %b", j, got[j], want);
      else n_pass++;
    end
  endtask

  task automatic test_out_of_range();
    logic [0:15] lit;
    logic [2:0]  want;
    int          ys [5];
    logic [15:0] tab [5];
    do_reset();
    wr(5'd0, 4'd1);
    wr(5'd1, 4'd14);
    wr(5'd7, 4'd14);
    wr(5'd8, 4'd0);
    // Row 5 over cells 0..1: '1' = D8, 'M' = C6
    run_scan(16, 37, 3'b111, 16, -1, 5'd0, 4'd0);
    lit = 16'hD8C6;
    for (int j = 0; j < 16; j++) begin
      want = lit[j] ? 3'b111 : 3'b000;
      n_checks++;
      if (got[j] !== want) $display("FAIL ignored_write px%0d: L=%b expected %b", j, got[j], want);
      else n_pass++;
    end
    // Cell 1 ('M') above, at top, at bottom and below the window.
    ys[0] = 31; tab[0] = 16'h0000;
    ys[1] = 32; tab[1] = 16'hC600;
    ys[2] = 47; tab[2] = 16'hC600;
    ys[3] = 48; tab[3] = 16'h0000;
    ys[4] = 33; tab[4] = 16'hEE00;
    for (int k = 0; k < 5; k++) begin
      run_scan(24, ys[k], 3'b111, 8, -1, 5'd0, 4'd0);
      lit = tab[k];
      for (int j = 0; j < 8; j++) begin
        want = lit[j] ? 3'b111 : 3'b000;
        n_checks++;
        if (got[j] !== want)
          $display("FAIL y_edge y=%0d px%0d: L=%b expected %b", ys[k], j, got[j], want);
        else n_pass++;
      end
    end
    // Right edge: columns 78..81 of row 0 in cell 7 ('M' = C6); 80 and beyond are outside.
    run_scan(78, 32, 3'b111, 4, -1, 5'd0, 4'd0);
    lit = 16'h8000;
    for (int j = 0; j < 4; j++) begin
      want = lit[j] ? 3'b111 : 3'b000;
      n_checks++;
      if (got[j] !== want) $display("FAIL x_edge px%0d: L=%b expected %b", j, got[j], want);
      else n_pass++;
    end
  endtask

  task automatic test_cursor();
    logic [0:15] lit;
    logic [2:0]  want;
    logic [15:0] tab  [8];
    logic [4:0]  cpos [8];
    cpos[0] = 5'd0; cpos[1] = 5'd0; cpos[2] = 5'd0; cpos[3] = 5'd0;
    cpos[4] = 5'd0; cpos[5] = 5'd0; cpos[6] = 5'd8; cpos[7] = 5'd1;
`ifdef CURSOR_PARPADEO_EN
    // Phase per frame 0,0,1,1,0,0,1,1; cell 1 holds 'M' (row 1 = EE).
    tab[0] = 16'h00EE; tab[1] = 16'h00EE; tab[2] = 16'hFFEE; tab[3] = 16'hFFEE;
    tab[4] = 16'h00EE; tab[5] = 16'h00EE; tab[6] = 16'h00EE; tab[7] = 16'h0011;
`else
    for (int f = 0; f < 8; f++) tab[f] = 16'h00EE;
`endif
    do_reset();
    wr(5'd1, 4'd14);
    for (int f = 0; f < 8; f++) begin
      cursor_pos = cpos[f];
      if (f > 0) begin
        X = 10'd0; Y = 10'd0;
        step();
      end
      run_scan(16, 33, 3'b101, 16, -1, 5'd0, 4'd0);
      lit = tab[f];
      for (int j = 0; j < 16; j++) begin
        want = lit[j] ? 3'b101 : 3'b000;
        n_checks++;
        if (got[j] !== want)
          $display("FAIL cursor frame%0d px%0d: L=%b expected %b", f, j, got[j], want);
        else n_pass++;
      end
    end
    cursor_pos = 5'd31;
  endtask

  task automatic test_reset_mid_row();
    do_reset();
    wr(5'd2, 4'd12);
    X = 10'd32; Y = 10'd39; {R, G, B} = 3'b111;
    step();
    step();
    step();
    n_checks++;
    if (L !== 3'b111) $display("FAIL lit_before_reset: L=%b expected 111", L);
    else n_pass++;
    reset = 1'b1;
    step();
    n_checks++;
    if (L !== 3'b000) $display("FAIL reset_next_edge: L=%b expected 000", L);
    else n_pass++;
    step();
    reset = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step();
      n_checks++;
      if (L !== 3'b000) $display("FAIL post_reset edge%0d: L=%b expected 000", i, L);
      else n_pass++;
    end
    run_scan(32, 39, 3'b111, 8, -1, 5'd0, 4'd0);
    for (int j = 0; j < 8; j++) begin
      n_checks++;
      if (got[j] !== 3'b000) $display("FAIL buffer_cleared px%0d: L=%b expected 000", j, got[j]);
      else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_glyph();
    test_write_collision();
    test_out_of_range();
    test_cursor();
    test_reset_mid_row();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
